matvec_stream_ctrl: RTL and testbench

Parametrised successor to the row-block matrix-vector controller. Computes y = A·x for a runtime-sized matrix (n_rows × n_cols, up to MAX_ROWS × MAX_COLS) on PE_NUM parallel MAC lanes. It takes x and A over valid/ready streams instead of flat arrays, and returns y over a valid/ready stream. Adds remainder-row masking, optional ReLU, output saturation and full backpressure. It sits between the weight/activation memory streamers and the next layer's input buffer.

---
 rtl/matvec_stream_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_matvec_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_stream_ctrl.sv
// matvec_stream_ctrl: tiled streaming y = A*x controller over PE_NUM MAC lanes
// with remainder-row masking, optional ReLU, output saturation and backpressure.
module matvec_stream_ctrl #(
    parameter int MAX_ROWS = 1024,
    parameter int MAX_COLS = 1024,
    parameter int DW       = 16,
    parameter int PE_NUM   = 8,
    parameter int OW       = 32,
    parameter int ACC_W    = 2*DW+$clog2(MAX_COLS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(MAX_ROWS):0]   n_rows,
    input  logic [$clog2(MAX_COLS):0]   n_cols,
    input  logic                        relu_en,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [DW-1:0]               x_data,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [PE_NUM*DW-1:0]        a_data,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic [OW-1:0]               y_data,
    output logic                        y_last,
    output logic                        busy,
    output logic                        done
);
    localparam int NRW = $clog2(MAX_ROWS)+1;
    localparam int NCW = $clog2(MAX_COLS)+1;
    localparam int XAW = $clog2(MAX_COLS);
    localparam int RW  = NRW+1;
    localparam int LW  = $clog2(PE_NUM+1);
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_X, MAC, DRAIN, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [NRW-1:0]           nr_q, nr_d;
    logic [NCW-1:0]           nc_q, nc_d;
    logic                     relu_q, relu_d;
    logic [RW-1:0]            row_base_q, row_base_d;
    logic [NCW-1:0]           col_q, col_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic signed [ACC_W-1:0]  acc_q [PE_NUM];
    logic signed [ACC_W-1:0]  acc_d [PE_NUM];
    logic                     x_ready_q, x_ready_d, a_ready_q, a_ready_d;
    logic                     y_valid_q, y_valid_d, y_last_q, y_last_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic [OW-1:0]            y_data_q, y_data_d;

    logic [DW-1:0]            xbuf [MAX_COLS];
    logic signed [DW-1:0]     x_cur;
    logic [PE_NUM-1:0]        lane_act;
    logic                     lane_more, col_last, tile_more, cfg_ok;
    logic                     x_fire, a_fire, y_fire;
    logic signed [ACC_W-1:0]  acc_sel, relu_v;
    logic [OW-1:0]            y_sat;

    assign x_fire    = x_ready_q && x_valid;
    assign a_fire    = a_ready_q && a_valid;
    assign y_fire    = y_valid_q && y_ready;
    assign x_cur     = xbuf[col_q[XAW-1:0]];
    assign col_last  = col_q == nc_q - NCW'(1);
    assign tile_more = (row_base_q + RW'(PE_NUM)) < RW'(nr_q);
    assign cfg_ok    = n_rows != '0 && n_rows <= NRW'(MAX_ROWS) && n_cols != '0 && n_cols <= NCW'(MAX_COLS);
    assign relu_v    = (relu_q && acc_sel[ACC_W-1]) ? '0 : acc_sel;
    assign y_sat     = relu_v > OMAX ? OMAX[OW-1:0] : relu_v < OMIN ? OMIN[OW-1:0] : relu_v[OW-1:0];

    always_comb begin
        lane_more = 1'b0;
        acc_sel   = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            lane_act[p] = (row_base_q + RW'(p)) < RW'(nr_q);
            if (LW'(p) == lane_q) begin
                lane_more = lane_act[p];
                acc_sel   = acc_q[p];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        nr_d       = nr_q;
        nc_d       = nc_q;
        relu_d     = relu_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        lane_d     = lane_q;
        acc_d      = acc_q;
        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        y_last_d   = y_last_q;
        case (state_q)
            IDLE: if (start && cfg_ok) begin
                nr_d       = n_rows;
                nc_d       = n_cols;
                relu_d     = relu_en;
                row_base_d = '0;
                col_d      = '0;
                state_d    = LOAD_X;
            end
            LOAD_X: if (x_fire) begin
                col_d = col_last ? '0 : col_q + NCW'(1);
                if (col_last) begin
                    acc_d   = '{default: '0};
                    state_d = MAC;
                end
            end
            MAC: if (a_fire) begin
                for (int p = 0; p < PE_NUM; p++)
                    if (lane_act[p])
                        acc_d[p] = acc_q[p] + ACC_W'($signed(a_data[p*DW +: DW]) * x_cur);
                col_d  = col_last ? '0 : col_q + NCW'(1);
                lane_d = '0;
                if (col_last) state_d = DRAIN;
            end
            DRAIN: if (!y_valid_q || y_fire) begin
                // Lane 0 is always active, so the first load on entry always succeeds.
                if (lane_more) begin
                    y_valid_d = 1'b1;
                    y_data_d  = y_sat;
                    y_last_d  = (row_base_q + RW'(lane_q)) == RW'(nr_q) - RW'(1);
                    lane_d    = lane_q + LW'(1);
                end else begin
                    y_valid_d = 1'b0;
                    y_last_d  = 1'b0;
                    if (tile_more) begin
                        row_base_d = row_base_q + RW'(PE_NUM);
                        acc_d      = '{default: '0};
                        col_d      = '0;
                        state_d    = MAC;
                    end else
                        state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        x_ready_d = state_d == LOAD_X;
        a_ready_d = state_d == MAC;
        busy_d    = state_d != IDLE;
        done_d    = state_d == FINISH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nr_q       <= '0;
            nc_q       <= '0;
            relu_q     <= 1'b0;
            row_base_q <= '0;
            col_q      <= '0;
            lane_q     <= '0;
            acc_q      <= '{default: '0};
            x_ready_q  <= 1'b0;
            a_ready_q  <= 1'b0;
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            y_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nr_q       <= nr_d;
            nc_q       <= nc_d;
            relu_q     <= relu_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            x_ready_q  <= x_ready_d;
            a_ready_q  <= a_ready_d;
            y_valid_q  <= y_valid_d;
            y_data_q   <= y_data_d;
            y_last_q   <= y_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk)
        if (x_fire) xbuf[col_q[XAW-1:0]] <= x_data;

    assign x_ready = x_ready_q;
    assign a_ready = a_ready_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_matvec_stream_ctrl.sv
// tb_matvec_stream_ctrl: scoreboard bench for matvec_stream_ctrl with PE_NUM=2, OW=16
module tb_matvec_stream_ctrl;
    localparam int MR = 16, MC = 16, DW = 16, PE = 2, OW = 16;

    logic clk = 0, rst_n = 0, start = 0, relu_en = 0;
    logic x_valid = 0, a_valid = 0, y_ready = 0;
    logic [4:0] n_rows = '0, n_cols = '0;
    logic [DW-1:0] x_data = '0;
    logic [PE*DW-1:0] a_data = '0;
    logic x_ready, a_ready, y_valid, y_last, busy, done;
    logic [OW-1:0] y_data;

    matvec_stream_ctrl #(.MAX_ROWS(MR), .MAX_COLS(MC), .DW(DW), .PE_NUM(PE), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .relu_en(relu_en), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    typedef struct packed { logic [OW-1:0] d; logic l; } exp_t;
    exp_t q[$];
    int total = 0, bad = 0, done_cnt = 0;
    int am [16][16];
    int xv [16];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic push_model(input int nr, input int nc, input int relu);
        exp_t e;
        for (int r = 0; r < nr; r++) begin
            longint acc = 0;
            for (int c = 0; c < nc; c++) acc += longint'(am[r][c]) * longint'(xv[c]);
            if (relu != 0 && acc < 0) acc = 0;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            e.d = acc[15:0];
            e.l = (r == nr - 1);
            q.push_back(e);
        end
    endtask

    task automatic drive_x(input int nc, input int st);
        int i = 0, guard = 0;
        while (i < nc && guard < 5000) begin
            @(posedge clk); #1;
            x_valid = ($urandom_range(99) >= st);
            x_data = xv[i][15:0];
            @(negedge clk);
            if (x_valid && x_ready) i++;
            guard++;
        end
        @(posedge clk); #1 x_valid = 0;
        total++;
        if (i != nc) begin bad++; $display("FAIL x_timeout got=%0d want=%0d", i, nc); end
    endtask

    task automatic drive_a(input int nr, input int nc, input int nbeats, input int st);
        int k = 0, guard = 0;
        while (k < nbeats && guard < 5000) begin
            int rb, c, v;
            @(posedge clk); #1;
            rb = (k / nc) * PE;
            c = k % nc;
            for (int p = 0; p < PE; p++) begin
                v = (rb + p < nr) ? am[rb+p][c] : int'($urandom);
                a_data[p*DW +: DW] = v[15:0];
            end
            a_valid = ($urandom_range(99) >= st);
            @(negedge clk);
            if (a_valid && a_ready) k++;
            guard++;
        end
        @(posedge clk); #1 a_valid = 0;
        total++;
        if (k != nbeats) begin bad++; $display("FAIL a_timeout got=%0d want=%0d", k, nbeats); end
    endtask

    task automatic consume(input int n, input int st);
        int got = 0, guard = 0;
        logic stall = 0;
        logic [OW-1:0] hold = '0;
        exp_t e;
        while (got < n && guard < 5000) begin
            @(posedge clk); #1 y_ready = ($urandom_range(99) >= st);
            @(negedge clk);
            if (stall) begin
                total++;
                if (y_valid !== 1'b1 || y_data !== hold) begin
                    bad++; $display("FAIL y_hold valid=%b data=%h want=1/%h", y_valid, y_data, hold);
                end
            end
            stall = y_valid && !y_ready;
            hold = y_data;
            if (y_valid === 1'b1 && y_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL y_extra data=%h", y_data);
                end else begin
                    e = q.pop_front();
                    if (y_data !== e.d) begin bad++; $display("FAIL y_data got=%h want=%h", y_data, e.d); end
                    total++;
                    if (y_last !== e.l) begin bad++; $display("FAIL y_last got=%b want=%b", y_last, e.l); end
                end
                got++;
            end
            guard++;
        end
        @(posedge clk); #1 y_ready = 0;
        total++;
        if (got != n) begin bad++; $display("FAIL y_timeout got=%0d want=%0d", got, n); end
    endtask

    task automatic pulse_start(input int nr, input int nc, input int relu);
        @(posedge clk); #1;
        start = 1; n_rows = 5'(nr); n_cols = 5'(nc); relu_en = (relu != 0);
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run_job(input int nr, input int nc, input int relu, input int xs, input int as, input int ys);
        int d0 = done_cnt;
        push_model(nr, nc, relu);
        pulse_start(nr, nc, relu);
        total++;
        if (x_ready !== 1'b1) begin bad++; $display("FAIL start_to_x_ready got=%b want=1", x_ready); end
        fork
            drive_x(nc, xs);
            drive_a(nr, nc, ((nr + PE - 1) / PE) * nc, as);
            consume(nr, ys);
        join
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_pulses got=%0d want=1", done_cnt - d0); end
        total++;
        if (busy !== 1'b0 || y_valid !== 1'b0) begin bad++; $display("FAIL job_idle busy=%b y_valid=%b want=0/0", busy, y_valid); end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL leftover_expect got=%0d want=0", q.size()); end
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({x_ready, a_ready, y_valid, y_last, busy, done} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {x_ready, a_ready, y_valid, y_last, busy, done});
        end
        total++;
        if (y_data !== '0) begin bad++; $display("FAIL reset_ydata got=%h want=0", y_data); end
        #1 rst_n = 1;
    endtask

    task automatic test_bad_cfg();
        int d0 = done_cnt;
        pulse_start(0, 4, 0);
        total++;
        if (busy !== 1'b0 || x_ready !== 1'b0) begin bad++; $display("FAIL zero_rows busy=%b x_ready=%b want=0/0", busy, x_ready); end
        pulse_start(4, 17, 0);
        total++;
        if (busy !== 1'b0 || x_ready !== 1'b0) begin bad++; $display("FAIL big_cols busy=%b x_ready=%b want=0/0", busy, x_ready); end
        pulse_start(17, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done_cnt != d0) begin bad++; $display("FAIL big_rows busy=%b done=%0d want=0/0", busy, done_cnt - d0); end
    endtask

    task automatic test_identity();
        for (int r = 0; r < 4; r++) begin
            xv[r] = r + 1;
            for (int c = 0; c < 4; c++) am[r][c] = (r == c) ? 1 : 0;
        end
        run_job(4, 4, 0, 0, 0, 0);
    endtask

    task automatic test_remainder();
        for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) am[r][c] = 2;
        xv[0] = 3; xv[1] = -1;
        run_job(3, 2, 0, 0, 0, 0);
    endtask

    task automatic test_relu();
        am[0][0] = 1; am[0][1] = 1; xv[0] = -5; xv[1] = 2;
        run_job(1, 2, 1, 0, 0, 0);
        run_job(1, 2, 0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 4; c++) begin
            xv[c] = 32767; am[0][c] = 32767; am[1][c] = -32768;
        end
        run_job(2, 4, 0, 0, 0, 0);
    endtask

    task automatic test_random_stall();
        for (int r = 0; r < 8; r++) begin
            xv[r] = $urandom_range(200) - 100;
            for (int c = 0; c < 8; c++) am[r][c] = (r == 7) ? int'($urandom_range(65535)) - 32768 : $urandom_range(200) - 100;
        end
        run_job(8, 8, 0, 50, 50, 30);
        run_job(8, 8, 1, 50, 50, 30);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            xv[r] = $urandom_range(60) - 30;
            for (int c = 0; c < 5; c++) am[r][c] = $urandom_range(60) - 30;
        end
        run_job(5, 3, 0, 0, 0, 0);
        run_job(3, 5, 1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_drain();
        int guard = 0;
        for (int r = 0; r < 4; r++) begin
            xv[r] = r + 3;
            for (int c = 0; c < 2; c++) am[r][c] = r - c + 1;
        end
        y_ready = 0;
        pulse_start(4, 2, 0);
        drive_x(2, 0);
        drive_a(4, 2, 2, 0);
        @(negedge clk);
        while (y_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        total++;
        if (y_valid !== 1'b1) begin bad++; $display("FAIL drain_reach got=%b want=1", y_valid); end
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (y_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset y_valid=%b busy=%b want=0/0", y_valid, busy); end
        rst_n = 1;
        am[0][0] = 2; am[0][1] = -1; am[1][0] = 4; am[1][1] = 5;
        xv[0] = 7; xv[1] = -3;
        run_job(2, 2, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_bad_cfg();
        test_identity();
        test_remainder();
        test_relu();
        test_saturate();
        test_random_stall();
        test_back_to_back();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
